sccb_init_sequencer: RTL and testbench
======================================

// Module: sccb_init_sequencer
// PURPOSE
//   Hardware replacement for the soft-CPU SCCB bring-up path: walks a fixed table of
//   OV7670 register writes and drives the SCCB engine through its Start/WR/Data/Busy handshake.
//   Optionally reads back each register and counts mismatches.
//   Sits between the camera reset/power logic and the SCCB engine.
//   Muxed against the APB register block by the top level.
// PARAMETERS
//   DEV_ID      8'h42     SCCB write device ID; read ID = DEV_ID|1
//   NUM_ENTRIES 8'd80     table length, including the END entry
//   DELAY_CYC   20'd50000 settle cycles for a DELAY entry and for the post-cam_ready wait
//   TIMEOUT_CYC 20'd200000 max cycles a single SCCB transaction may keep busy asserted
// PORTS
//   clk          in   1   system clock
//   rstn         in   1   async active-low reset
//   cam_ready    in   1   camera out of reset (level)
//   cfg_start    in   1   1-cycle pulse: (re)run the table
//   verify_en    in   1   sampled at start: read back after each write
//   sccb_start   out  1   1-cycle transaction request to SCCB engine
//   sccb_wr      out  4   phase-enable word to engine
//   sccb_data    out  32  {8'h00, dev_id, reg_addr, reg_data}
//   sccb_busy    in   1   engine busy
//   sccb_rdata   in   8   engine read result, valid when busy falls after a read
//   cfg_busy     out  1   sequence in progress
//   cfg_done     out  1   sticky: table completed; cleared on cfg_start
//   cfg_error    out  1   sticky: busy timeout; cleared on cfg_start
//   mismatch_cnt out  8   saturating readback mismatch count
//   cur_index    out  8   table index being processed
// BEHAVIOUR
//   Reset values
//     All outputs are 0. State is IDLE.
//     An auto-run flag is set at reset: the first rising cam_ready acts as cfg_start.
//   Table format (from sccb_init_rom)
//     Each entry is {addr[7:0], data[7:0]}.
//     addr=8'hFF, data=8'hF0: DELAY entry.
//     addr=8'hFF, data=8'hFF: END entry.
//     ROM read latency is 1 cycle.
//   FSM states
//     IDLE -> WAIT_RDY -> SETTLE -> FETCH -> DECODE -> {WR_ISSUE | DELAY | DONE}.
//     WR_ISSUE -> WR_WAIT -> {RD_ISSUE (verify) | NEXT}.
//     RD_ISSUE -> RD_WAIT -> CHECK -> NEXT -> FETCH.
//   Start and ready
//     IDLE waits for cfg_start or auto-run.
//     WAIT_RDY holds until cam_ready=1.
//     SETTLE counts DELAY_CYC cycles.
//   Transactions
//     *_ISSUE drives sccb_start=1 for exactly one cycle. sccb_wr and sccb_data stay stable
//     from ISSUE until the matching WAIT exits.
//     Write: sccb_wr=4'b0111, data {00,DEV_ID,addr,data}.
//     Read: sccb_wr=4'b1011, data {00,DEV_ID|1,addr,00}.
//   WAIT states
//     First wait for busy=1 (at most 4 cycles, else treat as complete), then wait for busy=0.
//     A shared 20-bit timer runs during WAIT.
//     Timer reaching TIMEOUT_CYC -> ERROR: cfg_error=1, cfg_busy=0, go to IDLE.
//   CHECK
//     If sccb_rdata != data, increment mismatch_cnt, saturating at 8'hFF.
//     Register 8'h12 is never verified; its write is a soft reset.
//   DELAY
//     Counts DELAY_CYC cycles, then goes to NEXT.
//   DONE
//     cfg_done=1, cfg_busy=0, return to IDLE.
//     The index also terminates when it reaches NUM_ENTRIES-1.
//   Status
//     cfg_busy=1 in every state except IDLE.
//     cfg_start while busy is ignored.
//     cfg_start in IDLE clears done, error, mismatch_cnt and the index.
//   Mid-sequence reset
//     If cam_ready falls mid-sequence, abort immediately to WAIT_RDY. Index restarts at 0.
//     No sccb_start is issued while cam_ready=0.
// STRUCTURE
//   Shared package cam_cfg_pkg
//     SCCB_WR3=4'b0111, SCCB_RD2=4'b1011.
//     ADDR_CTRL=8'hFF, CODE_DELAY=8'hF0, CODE_END=8'hFF, REG_COM7=8'h12.
//     FSM state enum.
//   Sub-module sccb_init_rom
//     Registered case table: index[7:0] -> entry[15:0].
//     Entry 0 = {12,80}, entry 1 = DELAY, then the RGB444 VGA set, last = END.
// TESTING
//   1) Reset, cam_ready=1 after 100 cycles, engine model with busy=20 cycles
//      -> first sccb_start no earlier than DELAY_CYC+100; data=32'h00421280; wr=4'b0111.
//   2) Full run, verify_en=0 -> one start per non-control entry, DELAY gap after entry 0,
//      cfg_done=1, mismatch_cnt=0.
//   3) verify_en=1, model returns data^1 for addr 8'h40 -> mismatch_cnt=1;
//      no read is issued for 8'h12; read data word = 32'h00434000.
//   4) Model holds busy=1 forever on entry 3 -> cfg_error=1 after TIMEOUT_CYC, cfg_done=0,
//      cur_index=3.
//   5) cam_ready dropped mid-run, then restored -> no start while low; rerun from index 0;
//      cfg_done=1.
//   6) cfg_start pulsed while cfg_busy=1 -> ignored; after done, cfg_start clears status and reruns.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared constants and types for the OV7670 SCCB bring-up sequencer.
package cam_cfg_pkg;

  // Phase-enable words understood by the SCCB engine
  localparam logic [3:0] SCCB_WR3 = 4'b0111;  // 3-phase write: id, addr, data
  localparam logic [3:0] SCCB_RD2 = 4'b1011;  // 2-phase write + read cycle

  // Table control codes
  localparam logic [7:0] ADDR_CTRL  = 8'hFF;
  localparam logic [7:0] CODE_DELAY = 8'hF0;
  localparam logic [7:0] CODE_END   = 8'hFF;
  localparam logic [7:0] REG_COM7   = 8'h12;  // soft-reset register, never read back

  // Last timer value at which a WAIT still expects busy to rise (4 cycles: 0..3)
  localparam logic [19:0] BUSY_ARM_LAST = 20'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_SETTLE,
    ST_FETCH,
    ST_DECODE,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_CHECK,
    ST_NEXT,
    ST_DELAY,
    ST_DONE
  } cfg_state_t;

  // Engine data word layout: {8'h00, device id, register address, register data}
  function automatic logic [31:0] sccb_word(input logic [7:0] id,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
    return {8'h00, id, addr, data};
  endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// OV7670 bring-up table: COM7 soft reset, settle delay, RGB444 VGA set, END.
// Each entry is {addr, data}; one cycle of read latency.
module sccb_init_rom
  import cam_cfg_pkg::*;
(
  input  logic        clk,
  input  logic [7:0]  index,
  output logic [15:0] entry
);

  logic [15:0] entry_next;

  // Table lookup; any index past the table reads as END
  always_comb begin
    entry_next = {ADDR_CTRL, CODE_END};
    case (index)
      8'd0:  entry_next = 16'h1280;  8'd1:  entry_next = {ADDR_CTRL, CODE_DELAY};
      8'd2:  entry_next = 16'h1204;  8'd3:  entry_next = 16'h8C02;
      8'd4:  entry_next = 16'h40D0;  8'd5:  entry_next = 16'h3A04;
      8'd6:  entry_next = 16'h1418;  8'd7:  entry_next = 16'h4FB3;
      8'd8:  entry_next = 16'h50B3;  8'd9:  entry_next = 16'h5100;
      8'd10: entry_next = 16'h523D;  8'd11: entry_next = 16'h53A7;
      8'd12: entry_next = 16'h54E4;  8'd13: entry_next = 16'h589E;
      8'd14: entry_next = 16'h3DC0;  8'd15: entry_next = 16'h1714;
      8'd16: entry_next = 16'h1802;  8'd17: entry_next = 16'h3280;
      8'd18: entry_next = 16'h1903;  8'd19: entry_next = 16'h1A7B;
      8'd20: entry_next = 16'h030A;  8'd21: entry_next = 16'h0F41;
      8'd22: entry_next = 16'h1E00;  8'd23: entry_next = 16'h330B;
      8'd24: entry_next = 16'h3C78;  8'd25: entry_next = 16'h6900;
      8'd26: entry_next = 16'h7400;  8'd27: entry_next = 16'hB084;
      8'd28: entry_next = 16'hB10C;  8'd29: entry_next = 16'hB20E;
      8'd30: entry_next = 16'hB380;  8'd31: entry_next = 16'h703A;
      8'd32: entry_next = 16'h7135;  8'd33: entry_next = 16'h7211;
      8'd34: entry_next = 16'h73F0;  8'd35: entry_next = 16'hA202;
      8'd36: entry_next = 16'h7A20;  8'd37: entry_next = 16'h7B10;
      8'd38: entry_next = 16'h7C1E;  8'd39: entry_next = 16'h7D35;
      8'd40: entry_next = 16'h7E5A;  8'd41: entry_next = 16'h7F69;
      8'd42: entry_next = 16'h8076;  8'd43: entry_next = 16'h8180;
      8'd44: entry_next = 16'h8288;  8'd45: entry_next = 16'h838F;
      8'd46: entry_next = 16'h8496;  8'd47: entry_next = 16'h85A3;
      8'd48: entry_next = 16'h86AF;  8'd49: entry_next = 16'h87C4;
      8'd50: entry_next = 16'h88D7;  8'd51: entry_next = 16'h89E8;
      8'd52: entry_next = 16'h13E0;  8'd53: entry_next = 16'h0000;
      8'd54: entry_next = 16'h1000;  8'd55: entry_next = 16'h0D40;
      8'd56: entry_next = 16'hA505;  8'd57: entry_next = 16'hAB07;
      8'd58: entry_next = 16'h2495;  8'd59: entry_next = 16'h2533;
      8'd60: entry_next = 16'h26E3;  8'd61: entry_next = 16'h9F78;
      8'd62: entry_next = 16'hA068;  8'd63: entry_next = 16'hA103;
      8'd64: entry_next = 16'hA6D8;  8'd65: entry_next = 16'hA7D8;
      8'd66: entry_next = 16'hA8F0;  8'd67: entry_next = 16'hA990;
      8'd68: entry_next = 16'hAA94;  8'd69: entry_next = 16'h13E5;
      8'd70: entry_next = 16'h0E61;  8'd71: entry_next = 16'h1602;
      8'd72: entry_next = 16'h2102;  8'd73: entry_next = 16'h2291;
      8'd74: entry_next = 16'h2907;  8'd75: entry_next = 16'h350B;
      8'd76: entry_next = 16'h371D;  8'd77: entry_next = 16'h3871;
      8'd78: entry_next = 16'h392A;  8'd79: entry_next = {ADDR_CTRL, CODE_END};
      default: entry_next = {ADDR_CTRL, CODE_END};
    endcase
  end

  // Registered read so the table maps onto block RAM / LUT ROM with an output register
  always_ff @(posedge clk) begin
    entry <= entry_next;
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the OV7670 init table and drives the SCCB engine Start/WR/Data/Busy handshake,
// optionally reading each register back and counting mismatches.
module sccb_init_sequencer
  import cam_cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ID      = 8'h42,
  parameter logic [7:0]  NUM_ENTRIES = 8'd80,
  parameter logic [19:0] DELAY_CYC   = 20'd50000,
  parameter logic [19:0] TIMEOUT_CYC = 20'd200000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cam_ready,
  input  logic        cfg_start,
  input  logic        verify_en,
  output logic        sccb_start,
  output logic [3:0]  sccb_wr,
  output logic [31:0] sccb_data,
  input  logic        sccb_busy,
  input  logic [7:0]  sccb_rdata,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [7:0]  mismatch_cnt,
  output logic [7:0]  cur_index
);

  cfg_state_t  state_reg;
  logic        auto_run_reg;
  logic        ready_q_reg;
  logic        verify_reg;
  logic        start_reg;
  logic        seen_busy_reg;
  logic [19:0] timer_reg;
  logic [7:0]  addr_reg;
  logic [7:0]  data_reg;
  logic [7:0]  rdata_reg;
  logic [15:0] rom_entry;

  logic ready_rise;
  logic is_ctrl;
  logic is_end;
  logic is_delay;
  logic last_index;
  logic xfer_end;
  logic run_req;

  sccb_init_rom u_rom (
    .clk   (clk),
    .index (cur_index),
    .entry (rom_entry)
  );

  assign ready_rise = cam_ready & ~ready_q_reg;
  assign run_req    = cfg_start | (auto_run_reg & ready_rise);
  assign is_ctrl    = (rom_entry[15:8] == ADDR_CTRL);
  assign is_end     = is_ctrl && (rom_entry[7:0] == CODE_END);
  assign is_delay   = is_ctrl && (rom_entry[7:0] == CODE_DELAY);
  assign last_index = (cur_index == (NUM_ENTRIES - 8'd1));

  // A transaction is over once busy has risen and fallen, or if busy never rose
  // within the first four WAIT cycles (engine finished too fast to observe).
  assign xfer_end = seen_busy_reg ? ~sccb_busy
                                  : (~sccb_busy && (timer_reg == BUSY_ARM_LAST));

  // Gate the request with cam_ready so a camera drop in the issue cycle cannot leak a start
  assign sccb_start = start_reg & cam_ready;

  // Sequencer FSM with all status and engine-facing outputs registered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      auto_run_reg  <= 1'b1;
      ready_q_reg   <= 1'b0;
      verify_reg    <= 1'b0;
      start_reg     <= 1'b0;
      seen_busy_reg <= 1'b0;
      timer_reg     <= 20'd0;
      addr_reg      <= 8'h00;
      data_reg      <= 8'h00;
      rdata_reg     <= 8'h00;
      sccb_wr       <= 4'b0000;
      sccb_data     <= 32'h0;
      cfg_busy      <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_error     <= 1'b0;
      mismatch_cnt  <= 8'h00;
      cur_index     <= 8'h00;
    end else begin
      ready_q_reg <= cam_ready;
      start_reg   <= 1'b0;  // request is a single-cycle pulse unless re-armed below

      if ((state_reg != ST_IDLE) && (state_reg != ST_WAIT_RDY) && !cam_ready) begin
        // Camera fell back into reset: abandon the pass and start over once it returns
        state_reg <= ST_WAIT_RDY;
        cur_index <= 8'h00;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (run_req) begin
              state_reg    <= ST_WAIT_RDY;
              auto_run_reg <= 1'b0;
              verify_reg   <= verify_en;
              cfg_busy     <= 1'b1;
              cfg_done     <= 1'b0;
              cfg_error    <= 1'b0;
              mismatch_cnt <= 8'h00;
              cur_index    <= 8'h00;
            end
          end
          ST_WAIT_RDY: begin
            if (cam_ready) begin
              state_reg <= ST_SETTLE;
              timer_reg <= 20'd0;
            end
          end
          ST_SETTLE: begin
            if (timer_reg == DELAY_CYC - 20'd1) state_reg <= ST_FETCH;
            else                                timer_reg <= timer_reg + 20'd1;
          end
          ST_FETCH: state_reg <= ST_DECODE;  // ROM output valid next cycle
          ST_DECODE: begin
            addr_reg <= rom_entry[15:8];
            data_reg <= rom_entry[7:0];
            if (is_end || last_index) begin
              state_reg <= ST_DONE;
            end else if (is_delay) begin
              state_reg <= ST_DELAY;
              timer_reg <= 20'd0;
            end else if (is_ctrl) begin
              state_reg <= ST_NEXT;  // unknown control code: skip it
            end else begin
              state_reg <= ST_WR_ISSUE;
              start_reg <= 1'b1;
              sccb_wr   <= SCCB_WR3;
              sccb_data <= sccb_word(DEV_ID, rom_entry[15:8], rom_entry[7:0]);
            end
          end
          ST_WR_ISSUE, ST_RD_ISSUE: begin
            state_reg     <= (state_reg == ST_WR_ISSUE) ? ST_WR_WAIT : ST_RD_WAIT;
            timer_reg     <= 20'd0;
            seen_busy_reg <= 1'b0;
          end
          ST_WR_WAIT, ST_RD_WAIT: begin
            if (timer_reg == TIMEOUT_CYC) begin
              state_reg <= ST_IDLE;
              cfg_error <= 1'b1;
              cfg_busy  <= 1'b0;
            end else begin
              timer_reg <= timer_reg + 20'd1;
              if (sccb_busy) seen_busy_reg <= 1'b1;
              if (xfer_end) begin
                if (state_reg == ST_RD_WAIT) begin
                  rdata_reg <= sccb_rdata;
                  state_reg <= ST_CHECK;
                end else if (verify_reg && (addr_reg != REG_COM7)) begin
                  state_reg <= ST_RD_ISSUE;
                  start_reg <= 1'b1;
                  sccb_wr   <= SCCB_RD2;
                  sccb_data <= sccb_word(DEV_ID | 8'h01, addr_reg, 8'h00);
                end else begin
                  state_reg <= ST_NEXT;
                end
              end
            end
          end
          ST_CHECK: begin
            if ((rdata_reg != data_reg) && (mismatch_cnt != 8'hFF))
              mismatch_cnt <= mismatch_cnt + 8'd1;
            state_reg <= ST_NEXT;
          end
          ST_DELAY: begin
            if (timer_reg == DELAY_CYC - 20'd1) state_reg <= ST_NEXT;
            else                                timer_reg <= timer_reg + 20'd1;
          end
          ST_NEXT: begin
            cur_index <= cur_index + 8'd1;
            state_reg <= ST_FETCH;
          end
          ST_DONE: begin
            cfg_done  <= 1'b1;
            cfg_busy  <= 1'b0;
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench for sccb_init_sequencer with a behavioural SCCB engine model.
module tb_sccb_init_sequencer;

  localparam int DLY   = 50;
  localparam int TO    = 300;
  localparam int LOG_N = 512;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cam_ready;
  logic        cfg_start;
  logic        verify_en;
  logic        sccb_start;
  logic [3:0]  sccb_wr;
  logic [31:0] sccb_data;
  logic        sccb_busy = 1'b0;
  logic [7:0]  sccb_rdata = 8'h00;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_error;
  logic [7:0]  mismatch_cnt;
  logic [7:0]  cur_index;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // engine model state
  int          n_txn      = 0;
  int          low_starts = 0;
  int          busy_left  = 0;
  bit          hang       = 1'b0;
  bit          stuck      = 1'b0;
  int          log_cyc  [LOG_N];
  logic [7:0]  log_idx  [LOG_N];
  logic [3:0]  log_wr   [LOG_N];
  logic [31:0] log_data [LOG_N];
  logic [7:0]  regs     [256];

  sccb_init_sequencer #(
    .DEV_ID      (8'h42),
    .NUM_ENTRIES (8'd80),
    .DELAY_CYC   (20'(DLY)),
    .TIMEOUT_CYC (20'(TO))
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cam_ready    (cam_ready),
    .cfg_start    (cfg_start),
    .verify_en    (verify_en),
    .sccb_start   (sccb_start),
    .sccb_wr      (sccb_wr),
    .sccb_data    (sccb_data),
    .sccb_busy    (sccb_busy),
    .sccb_rdata   (sccb_rdata),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_error    (cfg_error),
    .mismatch_cnt (mismatch_cnt),
    .cur_index    (cur_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SCCB engine: busy for 20 cycles per request, remembers writes, answers reads
  // (register 0x40 reads back with bit 0 flipped); can be told to hang on entry 3.
  always @(negedge clk) begin
    if (sccb_start) begin
      if (!cam_ready) low_starts++;
      if (n_txn < LOG_N) begin
        log_cyc[n_txn]  = cyc;
        log_idx[n_txn]  = cur_index;
        log_wr[n_txn]   = sccb_wr;
        log_data[n_txn] = sccb_data;
      end
      $display("txn %0d cyc=%0d idx=%0d wr=%b data=%h", n_txn, cyc, cur_index, sccb_wr, sccb_data);
      n_txn++;
      sccb_busy = 1'b1;
      busy_left = 20;
      hang      = stuck && (cur_index == 8'd3);
      if (sccb_wr == 4'b0111) regs[sccb_data[15:8]] = sccb_data[7:0];
      else sccb_rdata = regs[sccb_data[15:8]] ^ ((sccb_data[15:8] == 8'h40) ? 8'h01 : 8'h00);
    end else if (hang) begin
      if (!stuck) begin
        hang      = 1'b0;
        sccb_busy = 1'b0;
        busy_left = 0;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) sccb_busy = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!cfg_done && n < limit) begin
      tick();
      n++;
    end
    chk("wait_done", 32'(cfg_done), 32'd1);
  endtask

  task automatic scan(input int from, output int nw, output int nr, output int n12,
                      output logic [31:0] w40);
    int to;
    nw  = 0;
    nr  = 0;
    n12 = 0;
    w40 = 32'h0;
    to  = (n_txn < LOG_N) ? n_txn : LOG_N;
    for (int i = from; i < to; i++) begin
      if (log_wr[i] == 4'b0111) nw++;
      if (log_wr[i] == 4'b1011) begin
        nr++;
        if (log_data[i][15:8] == 8'h12) n12++;
        if (log_data[i][15:8] == 8'h40) w40 = log_data[i];
      end
    end
  endtask

  initial begin
    int          snap;
    int          rst_cyc;
    int          err_cyc;
    int          stuck_cyc;
    int          nw;
    int          nr;
    int          n12;
    int          n;
    logic [31:0] w40;
    logic [7:0]  idx_before;

    rstn = 1'b0; cam_ready = 1'b0; cfg_start = 1'b0; verify_en = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_start", 32'(sccb_start), 32'd0);
    chk("rst_wr", 32'(sccb_wr), 32'd0);
    chk("rst_data", sccb_data, 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_error", 32'(cfg_error), 32'd0);
    chk("rst_mism", 32'(mismatch_cnt), 32'd0);
    chk("rst_index", 32'(cur_index), 32'd0);

    // 1) auto-run on first cam_ready rise, verify off
    rstn = 1'b1;
    rst_cyc = cyc;
    repeat (100) tick();
    chk("t1_idle_no_rdy", 32'(cfg_busy), 32'd0);
    snap = n_txn;
    cam_ready = 1'b1;
    tick();
    tick();
    chk("t1_busy", 32'(cfg_busy), 32'd1);
    wait_done(20000);
    chk("t1_first_wr", 32'(log_wr[snap]), 32'h7);
    chk("t1_first_data", log_data[snap], 32'h00421280);
    chk("t1_first_late", 32'((log_cyc[snap] - rst_cyc) >= DLY + 100), 32'd1);

    // 2) full pass results
    scan(snap, nw, nr, n12, w40);
    chk("t2_writes", 32'(nw), 32'd78);
    chk("t2_reads", 32'(nr), 32'd0);
    chk("t2_second_idx", 32'(log_idx[snap + 1]), 32'd2);
    chk("t2_delay_gap", 32'((log_cyc[snap + 1] - log_cyc[snap]) >= DLY + 20), 32'd1);
    chk("t2_done", 32'(cfg_done), 32'd1);
    chk("t2_busy", 32'(cfg_busy), 32'd0);
    chk("t2_error", 32'(cfg_error), 32'd0);
    chk("t2_mism", 32'(mismatch_cnt), 32'd0);

    // 3) verify pass; also 6a) a cfg_start while busy is ignored
    tick();
    verify_en = 1'b1;
    snap = n_txn;
    pulse_start();
    chk("t3_clr_done", 32'(cfg_done), 32'd0);
    chk("t3_busy", 32'(cfg_busy), 32'd1);
    repeat (300) tick();
    idx_before = cur_index;
    pulse_start();
    tick();
    chk("t6_ignored", 32'((cur_index != 8'd0) && (cur_index >= idx_before)), 32'd1);
    chk("t6_still_busy", 32'(cfg_busy), 32'd1);
    wait_done(20000);
    scan(snap, nw, nr, n12, w40);
    chk("t3_writes", 32'(nw), 32'd78);
    chk("t3_reads", 32'(nr), 32'd76);
    chk("t3_no_rd_com7", 32'(n12), 32'd0);
    chk("t3_rd_word", w40, 32'h00434000);
    chk("t3_mism", 32'(mismatch_cnt), 32'd1);

    // 6b + 4) cfg_start after done clears status; engine hangs on entry 3
    tick();
    verify_en = 1'b0;
    stuck = 1'b1;
    snap = n_txn;
    pulse_start();
    chk("t6_clr_done", 32'(cfg_done), 32'd0);
    chk("t6_clr_mism", 32'(mismatch_cnt), 32'd0);
    chk("t6_clr_index", 32'(cur_index), 32'd0);
    n = 0;
    while (!cfg_error && n < DLY + TO + 2000) begin
      tick();
      n++;
    end
    err_cyc = cyc;
    chk("t4_error", 32'(cfg_error), 32'd1);
    chk("t4_done", 32'(cfg_done), 32'd0);
    chk("t4_busy", 32'(cfg_busy), 32'd0);
    chk("t4_index", 32'(cur_index), 32'd3);
    chk("t4_txns", 32'(n_txn - snap), 32'd3);
    stuck_cyc = 0;
    for (int i = snap; i < n_txn && i < LOG_N; i++)
      if (log_idx[i] == 8'd3) stuck_cyc = log_cyc[i];
    chk("t4_timeout_len", 32'(((err_cyc - stuck_cyc) >= TO) && ((err_cyc - stuck_cyc) <= TO + 4)), 32'd1);
    stuck = 1'b0;
    repeat (5) tick();

    // 5) camera drops mid-run, then returns
    pulse_start();
    chk("t5_clr_error", 32'(cfg_error), 32'd0);
    n = 0;
    while (cur_index != 8'd5 && n < 5000) begin
      tick();
      n++;
    end
    chk("t5_reached_5", 32'(cur_index), 32'd5);
    cam_ready = 1'b0;
    snap = n_txn;
    tick();
    chk("t5_abort_idx", 32'(cur_index), 32'd0);
    chk("t5_abort_busy", 32'(cfg_busy), 32'd1);
    repeat (30) tick();
    chk("t5_no_txn_low", 32'(n_txn - snap), 32'd0);
    cam_ready = 1'b1;
    wait_done(20000);
    scan(snap, nw, nr, n12, w40);
    chk("t5_restart_idx", 32'(log_idx[snap]), 32'd0);
    chk("t5_writes", 32'(nw), 32'd78);
    chk("t5_low_starts", 32'(low_starts), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
